dnn2ami_rd_path: RTL and testbench
==================================

Name: dnn2ami_rd_path

Overview:
- Read-direction counterpart of the DNNWeaver-to-AMI write path.
- Accepts DNNWeaver macro read requests (address, beat count, PU id) and fractures them into 8-byte AMI read requests.
- Routes in-order AMI read responses back into the requesting PU's input buffer and signals completion to the DNNWeaver memory controller.
- Sits between the DNNWeaver memory controller and the AMI memory port arbiter.

Parameters:
- NUM_PU, 2, number of processing units sharing the port.
- AXI_ADDR_WIDTH, 32, DNN-side address width; zero-extended to the 64-bit AMI address.
- AXI_DATA_WIDTH, 64, beat width; one AMI beat = 8 bytes.
- TX_SIZE_WIDTH, 10, width of the macro request beat count.
- NUM_PU_W, $clog2(NUM_PU)+1, PU id width.
- MACRO_Q_LOG_DEPTH, 9, log2 depth of the macro request FIFO.
- TAG_Q_LOG_DEPTH, 6, log2 depth of the outstanding-beat tag FIFO; also bounds outstanding reads.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rd_req  in  1  macro read request strobe.
- rd_pu_id  in  NUM_PU_W  destination PU.
- rd_req_size  in  TX_SIZE_WIDTH  number of 8-byte beats.
- rd_addr  in  AXI_ADDR_WIDTH  byte start address.
- rd_ready  out  1  path idle; a new macro read may be issued.
- rd_done  out  1  one-cycle pulse: last beat of a macro read delivered.
- reqValid  out  1  AMI read request valid.
- reqOut  out  $bits(AMIRequest)  AMI request: isWrite=0, size=8, data=0.
- reqOut_grant  in  1  arbiter accepts reqOut this cycle.
- respIn  in  $bits(AMIResponse)  AMI read response (valid, data, size).
- respGrant  out  1  response consumed this cycle.
- inbuf_full  in  NUM_PU  per-PU input buffer full.
- inbuf_push  out  NUM_PU  one-hot push into PU input buffer.
- data_to_inbuf  out  AXI_DATA_WIDTH  beat data, common to all PUs.
- err  out  1  sticky: response arrived with no outstanding tag.

Behaviour:
- Reset (asynchronous, active-high) clears all FIFOs, sequencer and counters.
- Output values while in reset: rd_ready=1, rd_done=0, reqValid=0, respGrant=0, inbuf_push=0, err=0.
- Macro enqueue:
  - rd_req && !macroQ_full enqueues {addr, size, pu_id}.
  - rd_req while full is dropped; the controller must honour rd_ready.
- rd_ready = macroQ_empty && state==IDLE && tagQ_empty (combinational).
- Sequencer FSM, states IDLE and ISSUE:
  - IDLE with macroQ non-empty: dequeue; load cur_addr, beats_left=size, cur_pu.
  - If size==0: discard, stay IDLE, no rd_done.
  - Otherwise go to ISSUE next cycle.
  - ISSUE: reqValid = !tagQ_full. reqOut.addr = zero-extended cur_addr.
  - On reqValid && reqOut_grant:
    - cur_addr += 8, modulo 2^AXI_ADDR_WIDTH.
    - beats_left -= 1.
    - Enqueue tag {pu_id=cur_pu, last=(beats_left==1)}.
  - On the grant of the final beat, go to IDLE.
  - Consecutive macros therefore have a one-cycle IDLE bubble.
- Response routing (AMI responses are in order):
  - respGrant = respIn.valid && !tagQ_empty && !inbuf_full[tag.pu_id].
  - On respGrant: inbuf_push[tag.pu_id]=1, data_to_inbuf=respIn.data, dequeue tag.
  - If the tag had last=1, rd_done pulses the following cycle (registered).
  - inbuf_full on the head PU stalls all responses (head-of-line); no reordering.
- respIn.valid with tagQ_empty (e.g. in-flight responses after a mid-operation reset):
  - respGrant=1 and the data is dropped.
  - err is set and held until reset.
- Same-cycle tag enqueue (issue) and dequeue (response) are both honoured; occupancy is unchanged.
- reqOut is combinational from state; it must not change while reqValid=1 and grant=0.
- rd_req is accepted in any state, including during ISSUE, and queues behind the active macro.

Decomposition:
- Reuse AMIRequest, AMIResponse and DNNWeaverMemReq from AMITypes.
- Add to the shared package: RdTag typedef {pu_id, last}, and the AMI_BEAT_BYTES=8 constant.
- Instantiate FIFO or SoftFIFO per USE_SOFT_FIFO for both the macro queue and the tag queue.
- One natural sub-module: dnn2ami_rd_resp_router (tag FIFO plus response demux).

Test Plan:
- Single read, pu 0, addr 0x100, size 4, grant always high.
  - Four requests at 0x100, 0x108, 0x110, 0x118, size 8.
  - Responses D0..D3 pushed to inbuf 0 in order.
  - rd_done pulses once, one cycle after D3; rd_ready returns to 1.
- Two macros back-to-back: pu 0 size 2 at 0x0, then pu 1 size 3 at 0x1000.
  - Tags route 2 beats to inbuf_push[0], then 3 to inbuf_push[1].
  - Two rd_done pulses.
- Grant withheld 5 cycles mid-macro.
  - reqOut stable throughout; no address skip or duplicate.
- inbuf_full[0] high for 10 cycles with responses pending.
  - respGrant=0 for those cycles, no pushes; data order preserved after release.
- Tag FIFO fill (size 100, responses withheld).
  - reqValid drops after 64 outstanding, resumes as responses drain.
- Assert rst mid-macro, then inject 2 stale responses.
  - Outputs at reset values; both responses granted and dropped; err=1.
- Address wrap: addr 0xFFFFFFF8, size 2.
  - Second request at 0x00000000.

Source files
------------

// File: rtl/dnn2ami_rd_path_pkg.sv
// Shared types and constants for the DNNWeaver-to-AMI read path.
package dnn2ami_rd_path_pkg;

    localparam int NUM_PU            = 2;
    localparam int AXI_ADDR_WIDTH    = 32;
    localparam int AXI_DATA_WIDTH    = 64;
    localparam int TX_SIZE_WIDTH     = 10;
    localparam int NUM_PU_W          = $clog2(NUM_PU) + 1;
    localparam int MACRO_Q_LOG_DEPTH = 9;
    localparam int TAG_Q_LOG_DEPTH   = 6;
    localparam int AMI_ADDR_WIDTH    = 64;
    localparam int AMI_SIZE_WIDTH    = 7;
    localparam int AMI_BEAT_BYTES    = 8;

    // AMI memory request as seen by the port arbiter
    typedef struct packed {
        logic                      isWrite;
        logic [AMI_ADDR_WIDTH-1:0] addr;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [AMI_SIZE_WIDTH-1:0] size;
    } AMIRequest;

    // AMI memory response, returned in request order
    typedef struct packed {
        logic                      valid;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [AMI_SIZE_WIDTH-1:0] size;
    } AMIResponse;

    // One DNNWeaver macro read request
    typedef struct packed {
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [TX_SIZE_WIDTH-1:0]  size;
        logic [NUM_PU_W-1:0]       pu_id;
    } DNNWeaverMemReq;

    // Per-beat tag: which PU the response belongs to, and whether it ends its macro
    typedef struct packed {
        logic [NUM_PU_W-1:0] pu_id;
        logic                last;
    } RdTag;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } rd_state_e;

    // One-hot PU select; ids beyond NUM_PU select nothing
    function automatic logic [NUM_PU-1:0] pu_onehot(input logic [NUM_PU_W-1:0] id);
        logic [NUM_PU-1:0] oh;
        for (int i = 0; i < NUM_PU; i++) begin
            oh[i] = (id == NUM_PU_W'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/dnn2ami_rd_path_if.sv
// Bundle of the DNNWeaver-side and AMI-side signals of the read path.
interface dnn2ami_rd_path_if;
    import dnn2ami_rd_path_pkg::*;

    logic                      rd_req;
    logic [NUM_PU_W-1:0]       rd_pu_id;
    logic [TX_SIZE_WIDTH-1:0]  rd_req_size;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr;
    logic                      rd_ready;
    logic                      rd_done;
    logic                      reqValid;
    AMIRequest                 reqOut;
    logic                      reqOut_grant;
    AMIResponse                respIn;
    logic                      respGrant;
    logic [NUM_PU-1:0]         inbuf_full;
    logic [NUM_PU-1:0]         inbuf_push;
    logic [AXI_DATA_WIDTH-1:0] data_to_inbuf;
    logic                      err;

    // Read path view
    modport master (
        input  rd_req, rd_pu_id, rd_req_size, rd_addr, reqOut_grant, respIn, inbuf_full,
        output rd_ready, rd_done, reqValid, reqOut, respGrant, inbuf_push, data_to_inbuf, err
    );

    // Environment view (memory controller, arbiter, PU buffers)
    modport slave (
        output rd_req, rd_pu_id, rd_req_size, rd_addr, reqOut_grant, respIn, inbuf_full,
        input  rd_ready, rd_done, reqValid, reqOut, respGrant, inbuf_push, data_to_inbuf, err
    );
endinterface

// File: rtl/dnn2ami_rd_path_fifo.sv
// Simple synchronous FIFO; push while full and pop while empty are ignored.
module dnn2ami_rd_path_fifo #(
    parameter int W     = 8,
    parameter int LOG_D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0]     mem_q [2**LOG_D];
    logic [LOG_D-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_D-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_D:0]   cnt_q, cnt_d;
    logic             do_push_s, do_pop_s;

    assign full      = (cnt_q == (LOG_D+1)'(2**LOG_D));
    assign empty     = (cnt_q == (LOG_D+1)'(0));
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign dout      = mem_q[rd_ptr_q];

    // Next pointer and occupancy values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + LOG_D'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + LOG_D'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s && !do_pop_s) begin
            cnt_d = cnt_q + (LOG_D+1)'(1);
        end else if (do_pop_s && !do_push_s) begin
            cnt_d = cnt_q - (LOG_D+1)'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents are qualified by the occupancy count so need no reset
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end
endmodule

// File: rtl/dnn2ami_rd_resp_router.sv
// Tag FIFO plus response demux: steers in-order AMI read data to the owning PU.
module dnn2ami_rd_resp_router
    import dnn2ami_rd_path_pkg::*;
#(
    parameter int TAG_LOG_DEPTH = TAG_Q_LOG_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tag_push,
    input  RdTag                      tag_din,
    output logic                      tag_full,
    output logic                      tag_empty,
    input  AMIResponse                resp_in,
    input  logic [NUM_PU-1:0]         inbuf_full,
    output logic                      resp_grant,
    output logic [NUM_PU-1:0]         inbuf_push,
    output logic [AXI_DATA_WIDTH-1:0] data_to_inbuf,
    output logic                      rd_done,
    output logic                      err
);
    RdTag tag_head_s;
    logic tag_pop_s;
    logic head_full_s;
    logic stray_s;
    logic done_q, done_d;
    logic err_q, err_d;
    logic unused_size_s;

    assign unused_size_s = ^resp_in.size;

    dnn2ami_rd_path_fifo #(
        .W     ($bits(RdTag)),
        .LOG_D (TAG_LOG_DEPTH)
    ) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_push),
        .din   (tag_din),
        .pop   (tag_pop_s),
        .dout  (tag_head_s),
        .full  (tag_full),
        .empty (tag_empty)
    );

    assign data_to_inbuf = resp_in.data;
    assign rd_done       = done_q;
    assign err           = err_q;

    // Grant/push decision; a full buffer on the head PU blocks every response behind it
    always_comb begin
        head_full_s = 1'b0;
        resp_grant  = 1'b0;
        inbuf_push  = '0;
        tag_pop_s   = 1'b0;
        stray_s     = 1'b0;
        for (int i = 0; i < NUM_PU; i++) begin
            if (tag_head_s.pu_id == NUM_PU_W'(i)) begin
                head_full_s = inbuf_full[i];
            end else begin
                head_full_s = head_full_s;
            end
        end
        if (rst || !resp_in.valid) begin
            resp_grant = 1'b0;
        end else if (tag_empty) begin
            // Response with nobody waiting for it: swallow it and flag the error
            resp_grant = 1'b1;
            stray_s    = 1'b1;
        end else if (!head_full_s) begin
            resp_grant = 1'b1;
            tag_pop_s  = 1'b1;
            inbuf_push = pu_onehot(tag_head_s.pu_id);
        end else begin
            resp_grant = 1'b0;
        end
        done_d = tag_pop_s && tag_head_s.last;
        err_d  = err_q || stray_s;
    end

    // Completion pulse and sticky error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: rtl/dnn2ami_rd_path.sv
// DNNWeaver macro reads fractured into 8-byte AMI reads, with in-order response routing.
module dnn2ami_rd_path
    import dnn2ami_rd_path_pkg::*;
#(
    parameter int MACRO_LOG_DEPTH = MACRO_Q_LOG_DEPTH,
    parameter int TAG_LOG_DEPTH   = TAG_Q_LOG_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    dnn2ami_rd_path_if.master bus
);
    DNNWeaverMemReq            macro_din_s, macro_head_s;
    logic                      macro_push_s, macro_pop_s, macro_full_s, macro_empty_s;
    logic                      tag_full_s, tag_empty_s, tag_push_s;
    RdTag                      tag_din_s;
    logic                      req_valid_s;
    rd_state_e                 state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [TX_SIZE_WIDTH-1:0]  beats_left_q, beats_left_d;
    logic [NUM_PU_W-1:0]       cur_pu_q, cur_pu_d;

    assign macro_push_s = bus.rd_req && !macro_full_s;
    assign macro_din_s  = '{addr: bus.rd_addr, size: bus.rd_req_size, pu_id: bus.rd_pu_id};

    dnn2ami_rd_path_fifo #(
        .W     ($bits(DNNWeaverMemReq)),
        .LOG_D (MACRO_LOG_DEPTH)
    ) u_macro_q (
        .clk   (clk),
        .rst   (rst),
        .push  (macro_push_s),
        .din   (macro_din_s),
        .pop   (macro_pop_s),
        .dout  (macro_head_s),
        .full  (macro_full_s),
        .empty (macro_empty_s)
    );

    // Sequencer next-state: load a macro in IDLE, emit one beat per grant in ISSUE
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        cur_pu_d     = cur_pu_q;
        macro_pop_s  = 1'b0;
        req_valid_s  = 1'b0;
        tag_push_s   = 1'b0;
        tag_din_s    = '{pu_id: cur_pu_q, last: (beats_left_q == TX_SIZE_WIDTH'(1))};
        case (state_q)
            ST_IDLE: begin
                if (!macro_empty_s) begin
                    macro_pop_s  = 1'b1;
                    cur_addr_d   = macro_head_s.addr;
                    beats_left_d = macro_head_s.size;
                    cur_pu_d     = macro_head_s.pu_id;
                    // Zero-length macros are discarded without a completion
                    if (macro_head_s.size != TX_SIZE_WIDTH'(0)) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Tag FIFO depth bounds the number of outstanding reads
                req_valid_s = !tag_full_s;
                if (req_valid_s && bus.reqOut_grant) begin
                    tag_push_s   = 1'b1;
                    cur_addr_d   = cur_addr_q + AXI_ADDR_WIDTH'(AMI_BEAT_BYTES);
                    beats_left_d = beats_left_q - TX_SIZE_WIDTH'(1);
                    if (beats_left_q == TX_SIZE_WIDTH'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            cur_pu_q     <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            cur_pu_q     <= cur_pu_d;
        end
    end

    // Request is a pure function of sequencer state, so it holds steady while stalled
    assign bus.reqValid = req_valid_s;
    assign bus.reqOut   = '{isWrite: 1'b0,
                            addr:    AMI_ADDR_WIDTH'(cur_addr_q),
                            data:    '0,
                            size:    AMI_SIZE_WIDTH'(AMI_BEAT_BYTES)};
    assign bus.rd_ready = macro_empty_s && (state_q == ST_IDLE) && tag_empty_s;

    dnn2ami_rd_resp_router #(
        .TAG_LOG_DEPTH (TAG_LOG_DEPTH)
    ) u_router (
        .clk           (clk),
        .rst           (rst),
        .tag_push      (tag_push_s),
        .tag_din       (tag_din_s),
        .tag_full      (tag_full_s),
        .tag_empty     (tag_empty_s),
        .resp_in       (bus.respIn),
        .inbuf_full    (bus.inbuf_full),
        .resp_grant    (bus.respGrant),
        .inbuf_push    (bus.inbuf_push),
        .data_to_inbuf (bus.data_to_inbuf),
        .rd_done       (bus.rd_done),
        .err           (bus.err)
    );
endmodule

// File: tb/tb_dnn2ami_rd_path.sv
// Bench for dnn2ami_rd_path: directed and randomized reads against a beat-list model.
module tb_dnn2ami_rd_path;
    import dnn2ami_rd_path_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dnn2ami_rd_path_if bus();

    dnn2ami_rd_path dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // One expected 8-byte beat: address, owning PU, end-of-macro flag, data returned
    typedef struct {
        logic [31:0] addr;
        int          pu;
        bit          last;
        logic [63:0] data;
    } beat_t;

    beat_t       exp_q[$];   // beats still to be requested, in order
    beat_t       pend[$];    // beats requested, response not yet delivered
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          resp_en = 1'b0;
    bit          stale = 1'b0;
    bit          done_exp = 1'b0;
    bit          hold_prev = 1'b0;
    logic [63:0] last_addr = 64'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: drive the response, check every visible output, then advance
    task automatic step();
        bit                eg;
        logic [NUM_PU-1:0] ep;
        beat_t             b;
        if (stale) begin
            bus.respIn = '{valid: 1'b1, data: 64'hDEAD_BEEF_0BAD_F00D, size: 7'd8};
        end else if (resp_en && pend.size() > 0) begin
            bus.respIn = '{valid: 1'b1, data: pend[0].data, size: 7'd8};
        end else begin
            bus.respIn = '0;
        end
        #1;
        check("rd_done", bus.rd_done, done_exp);
        done_exp = 1'b0;
        if (hold_prev) begin
            check("hold_valid", bus.reqValid, 1'b1);
            check("hold_addr", bus.reqOut.addr, last_addr);
        end
        if (pend.size() >= 64) check("tag_full_stall", bus.reqValid, 1'b0);
        if (bus.respIn.valid) begin
            if (pend.size() == 0) begin
                eg = 1'b1;
                ep = '0;
            end else begin
                eg = !bus.inbuf_full[pend[0].pu];
                ep = eg ? NUM_PU'(1 << pend[0].pu) : '0;
            end
            check("respGrant", bus.respGrant, eg);
            check("inbuf_push", bus.inbuf_push, ep);
            if (eg && pend.size() > 0) begin
                check("inbuf_data", bus.data_to_inbuf, pend[0].data);
                done_exp = pend[0].last;
                void'(pend.pop_front());
            end
        end else begin
            check("idle_grant", bus.respGrant, 1'b0);
            check("idle_push", bus.inbuf_push, '0);
        end
        if (bus.reqValid && bus.reqOut_grant) begin
            if (exp_q.size() == 0) begin
                check("spurious_req", exp_q.size(), 1);
            end else begin
                b = exp_q.pop_front();
                check("req_addr", bus.reqOut.addr, {32'd0, b.addr});
                check("req_iswrite", bus.reqOut.isWrite, 1'b0);
                check("req_size", bus.reqOut.size, 7'd8);
                b.data = {$urandom, $urandom};
                pend.push_back(b);
            end
        end
        hold_prev = bus.reqValid && !bus.reqOut_grant;
        last_addr = bus.reqOut.addr;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one macro read for a cycle and expand it into the expected beat list
    task automatic macro(input int pu, input int size, input logic [31:0] addr);
        bus.rd_req      = 1'b1;
        bus.rd_pu_id    = NUM_PU_W'(pu);
        bus.rd_req_size = TX_SIZE_WIDTH'(size);
        bus.rd_addr     = addr;
        for (int i = 0; i < size; i++) begin
            exp_q.push_back('{addr: addr + 32'(8 * i), pu: pu, last: (i == size - 1), data: 64'd0});
        end
        step();
        bus.rd_req = 1'b0;
    endtask

    // Run with everything open until the model is empty, then expect an idle path
    task automatic drain(input int budget);
        int c;
        bus.reqOut_grant = 1'b1;
        bus.inbuf_full   = '0;
        resp_en          = 1'b1;
        c = 0;
        while (c < budget && (exp_q.size() > 0 || pend.size() > 0)) begin
            step();
            c++;
        end
        check("drain_left", exp_q.size() + pend.size(), 0);
        repeat (3) step();
        check("rd_ready_idle", bus.rd_ready, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_ready"}, bus.rd_ready, 1'b1);
        check({tag, "_rd_done"}, bus.rd_done, 1'b0);
        check({tag, "_reqValid"}, bus.reqValid, 1'b0);
        check({tag, "_respGrant"}, bus.respGrant, 1'b0);
        check({tag, "_inbuf_push"}, bus.inbuf_push, '0);
        check({tag, "_err"}, bus.err, 1'b0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.rd_req       = 1'b0;
        bus.rd_pu_id     = '0;
        bus.rd_req_size  = '0;
        bus.rd_addr      = '0;
        bus.reqOut_grant = 1'b1;
        bus.inbuf_full   = '0;
        bus.respIn       = '{valid: 1'b1, data: 64'h1234, size: 7'd8};
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        bus.respIn = '0;
        @(negedge clk);
        rst = 1'b0;

        // Single read, PU 0, four beats from 0x100
        resp_en = 1'b1;
        macro(0, 4, 32'h100);
        drain(60);

        // Two macros back to back on different PUs
        macro(0, 2, 32'h0);
        macro(1, 3, 32'h1000);
        drain(60);

        // Grant withheld five cycles mid-macro
        macro(1, 6, 32'h2000);
        step();
        step();
        bus.reqOut_grant = 1'b0;
        repeat (5) step();
        drain(60);

        // PU 0 buffer full for ten cycles with responses waiting
        resp_en = 1'b0;
        macro(0, 5, 32'h3000);
        repeat (8) step();
        bus.inbuf_full = 2'b01;
        resp_en        = 1'b1;
        repeat (10) step();
        drain(60);

        // Tag FIFO fill: 100 beats with responses held back
        resp_en = 1'b0;
        macro(1, 100, 32'h4000);
        repeat (80) step();
        #1;
        check("fill_reqValid", bus.reqValid, 1'b0);
        check("fill_outstanding", pend.size(), 64);
        drain(400);

        // Address wrap at the top of the 32-bit space
        macro(0, 2, 32'hFFFF_FFF8);
        drain(60);

        // Randomized macros, arbiter grants and buffer back-pressure
        for (int k = 0; k < 25; k++) begin
            bus.reqOut_grant = 1'($urandom_range(0, 3) != 0);
            bus.inbuf_full   = NUM_PU'($urandom_range(0, 3)) & NUM_PU'($urandom_range(0, 3));
            resp_en          = 1'($urandom_range(0, 3) != 0);
            macro($urandom_range(0, 1), $urandom_range(0, 8), {$urandom_range(0, 32'h1FFF_FFFF), 3'b000});
            for (int s = $urandom_range(0, 4); s > 0; s--) begin
                bus.reqOut_grant = 1'($urandom_range(0, 3) != 0);
                bus.inbuf_full   = NUM_PU'($urandom_range(0, 3)) & NUM_PU'($urandom_range(0, 3));
                step();
            end
        end
        drain(2000);

        // Reset mid-macro, then two stale responses
        resp_en = 1'b0;
        macro(0, 8, 32'h5000);
        repeat (4) step();
        rst        = 1'b1;
        bus.respIn = '0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        pend.delete();
        done_exp  = 1'b0;
        hold_prev = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        stale = 1'b1;
        step();
        step();
        stale = 1'b0;
        #1;
        check("err_sticky", bus.err, 1'b1);
        check("stale_ready", bus.rd_ready, 1'b1);
        @(negedge clk);
        step();
        check("err_held", bus.err, 1'b1);
        rst = 1'b1;
        #1;
        check("err_cleared", bus.err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        macro(1, 3, 32'h6000);
        drain(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
